// File: rtl/bip_defs_pkg.sv
// Shared encodings for the accumulator datapath: opcodes, mux selects,
// add/sub op values and control FSM state codes.
package bip_defs;

  localparam int OPC_W = 5;
  localparam int ST_W  = 3;

  localparam logic [OPC_W-1:0] OPC_HLT  = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_STO  = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_LD   = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_ADDI = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_SUBI = 5'b00111;

  localparam logic [1:0] SEL_A_RAM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;

  localparam logic SEL_B_RAM = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_FETCH  = 3'd1;
  localparam logic [ST_W-1:0] ST_DECODE = 3'd2;
  localparam logic [ST_W-1:0] ST_EXEC   = 3'd3;
  localparam logic [ST_W-1:0] ST_HALT   = 3'd4;

endpackage

// File: rtl/bip_decoder.sv
// Combinational map from FSM state and opcode to datapath selects/strobes.
// EXEC strobes come from the IR; the DECODE read strobe looks at the ROM word.
module bip_decoder
  import bip_defs::*;
(
  input  logic [ST_W-1:0]  state,
  input  logic [OPC_W-1:0] ir_opcode,
  input  logic [OPC_W-1:0] pm_opcode,
  output logic [1:0]       sel_a,
  output logic             sel_b,
  output logic             op,
  output logic             wr_acc,
  output logic             wr_ram,
  output logic             rd_ram
);

  always_comb begin
    sel_a  = SEL_A_RAM;
    sel_b  = SEL_B_RAM;
    op     = ALU_ADD;
    wr_acc = 1'b0;
    wr_ram = 1'b0;
    rd_ram = 1'b0;
    if (state == ST_DECODE) begin
      // Issued one cycle early so RAM read data is ready in EXEC.
      rd_ram = (pm_opcode == OPC_LD) || (pm_opcode == OPC_ADD) ||
               (pm_opcode == OPC_SUB);
    end else if (state == ST_EXEC) begin
      case (ir_opcode)
        OPC_STO:  wr_ram = 1'b1;
        OPC_LD:   wr_acc = 1'b1;
        OPC_LDI: begin
          sel_a  = SEL_A_IMM;
          wr_acc = 1'b1;
        end
        OPC_ADD: begin
          sel_a  = SEL_A_ALU;
          wr_acc = 1'b1;
        end
        OPC_ADDI: begin
          sel_a  = SEL_A_ALU;
          sel_b  = SEL_B_IMM;
          wr_acc = 1'b1;
        end
        OPC_SUB: begin
          sel_a  = SEL_A_ALU;
          op     = ALU_SUB;
          wr_acc = 1'b1;
        end
        OPC_SUBI: begin
          sel_a  = SEL_A_ALU;
          sel_b  = SEL_B_IMM;
          op     = ALU_SUB;
          wr_acc = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bip_control.sv
// Sequencer for the accumulator datapath: FETCH/DECODE/EXEC per instruction,
// holding PC, IR and an execution cycle counter. HALT is left only by reset.
module bip_control
  import bip_defs::*;
#(
  parameter int NBITS     = 16,
  parameter int OPCODE_W  = 5,
  parameter int OPERAND_W = 11,
  parameter int PC_W      = 11,
  parameter int CNT_W     = 32
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [OPCODE_W+OPERAND_W-1:0] i_pm_data,
  output logic [PC_W-1:0]           o_pm_addr,
  output logic [OPERAND_W-1:0]      o_data_addr,
  output logic [NBITS-1:0]          o_operand,
  output logic [1:0]                o_SelA,
  output logic                      o_SelB,
  output logic                      o_Op,
  output logic                      o_WrAcc,
  output logic                      o_WrRam,
  output logic                      o_RdRam,
  output logic                      o_halted,
  output logic [CNT_W-1:0]          o_cycle_count,
  output logic [ST_W-1:0]           o_state
);

  localparam int IW = OPCODE_W + OPERAND_W;

  logic [ST_W-1:0]     state;
  logic [PC_W-1:0]     pc;
  logic [IW-1:0]       ir;
  logic [CNT_W-1:0]    cnt;
  logic [OPCODE_W-1:0] ir_opcode;
  logic                running;

  assign ir_opcode = ir[IW-1:OPERAND_W];
  assign running   = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_EXEC);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ST_IDLE;
      pc    <= '0;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      if (running && (cnt != {CNT_W{1'b1}})) cnt <= cnt + CNT_W'(1);
      case (state)
        ST_IDLE:   if (i_start) state <= ST_FETCH;
        ST_FETCH:  state <= ST_DECODE;
        ST_DECODE: begin
          ir    <= i_pm_data;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (ir_opcode == OPC_HLT) begin
            state <= ST_HALT;
          end else begin
            pc    <= pc + PC_W'(1);
            state <= ST_FETCH;
          end
        end
        ST_HALT:   state <= ST_HALT;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  bip_decoder u_decoder (
    .state     (state),
    .ir_opcode (ir_opcode),
    .pm_opcode (i_pm_data[IW-1:OPERAND_W]),
    .sel_a     (o_SelA),
    .sel_b     (o_SelB),
    .op        (o_Op),
    .wr_acc    (o_WrAcc),
    .wr_ram    (o_WrRam),
    .rd_ram    (o_RdRam)
  );

  assign o_pm_addr     = pc;
  assign o_data_addr   = ir[OPERAND_W-1:0];
  assign o_operand     = {{(NBITS-OPERAND_W){ir[OPERAND_W-1]}}, ir[OPERAND_W-1:0]};
  assign o_halted      = (state == ST_HALT);
  assign o_cycle_count = cnt;
  assign o_state       = state;

endmodule

// File: tb/tb_bip_control.sv
// Directed bench for bip_control with a registered program ROM model and
// hand-computed expectations checked by immediate assertions.
module tb_bip_control;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DEC   = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pm_data = '0;
  logic [10:0] pm_addr;
  logic [10:0] data_addr;
  logic [15:0] operand;
  logic [1:0]  sel_a;
  logic        sel_b, op, wr_acc, wr_ram, rd_ram, halted;
  logic [31:0] cycle_count;
  logic [2:0]  state;

  logic [15:0] rom [0:2047];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) pm_data <= rom[pm_addr];

  bip_control dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_start       (start),
    .i_pm_data     (pm_data),
    .o_pm_addr     (pm_addr),
    .o_data_addr   (data_addr),
    .o_operand     (operand),
    .o_SelA        (sel_a),
    .o_SelB        (sel_b),
    .o_Op          (op),
    .o_WrAcc       (wr_acc),
    .o_WrRam       (wr_ram),
    .o_RdRam       (rd_ram),
    .o_halted      (halted),
    .o_cycle_count (cycle_count),
    .o_state       (state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic load_nops();
    for (int i = 0; i < 2048; i++) rom[i] = 16'hF800;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_wracc"}, {31'd0, wr_acc}, 32'd0);
    check({tag, "_wrram"}, {31'd0, wr_ram}, 32'd0);
    check({tag, "_op"},    {31'd0, op},     32'd0);
    check({tag, "_sela"},  {30'd0, sel_a},  32'd0);
    check({tag, "_selb"},  {31'd0, sel_b},  32'd0);
  endtask

  initial begin
    // Program 1: LDI 5, SUBI 0x7FF, ADD 0x010, STO 3, HLT
    load_nops();
    rom[0] = 16'h1805;
    rom[1] = 16'h3FFF;
    rom[2] = 16'h2010;
    rom[3] = 16'h0803;
    rom[4] = 16'h0000;
    do_reset();
    check("rst_state", {29'd0, state}, {29'd0, S_IDLE});
    check("rst_pc", {21'd0, pm_addr}, 32'd0);
    check("rst_cnt", cycle_count, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_rdram", {31'd0, rd_ram}, 32'd0);
    check("rst_operand", {16'd0, operand}, 32'd0);
    check_quiet("rst");

    pulse_start();
    check("p1_fetch_state", {29'd0, state}, {29'd0, S_FETCH});
    check("p1_fetch_pc", {21'd0, pm_addr}, 32'd0);
    check_quiet("p1_fetch");
    step();
    check("ldi_dec_state", {29'd0, state}, {29'd0, S_DEC});
    check("ldi_dec_rdram", {31'd0, rd_ram}, 32'd0);
    step();
    check("ldi_exec_state", {29'd0, state}, {29'd0, S_EXEC});
    check("ldi_sela", {30'd0, sel_a}, 32'd1);
    check("ldi_wracc", {31'd0, wr_acc}, 32'd1);
    check("ldi_wrram", {31'd0, wr_ram}, 32'd0);
    check("ldi_operand", {16'd0, operand}, 32'h0005);
    check("ldi_cnt", cycle_count, 32'd2);
    step();
    check("ldi_next_pc", {21'd0, pm_addr}, 32'd1);
    check("ldi_next_wracc", {31'd0, wr_acc}, 32'd0);
    step();
    step();
    check("subi_sela", {30'd0, sel_a}, 32'd2);
    check("subi_selb", {31'd0, sel_b}, 32'd1);
    check("subi_op", {31'd0, op}, 32'd1);
    check("subi_wracc", {31'd0, wr_acc}, 32'd1);
    check("subi_operand", {16'd0, operand}, 32'h0000FFFF);
    step();
    check("add_fetch_pc", {21'd0, pm_addr}, 32'd2);
    step();
    check("add_dec_rdram", {31'd0, rd_ram}, 32'd1);
    step();
    check("add_rdram_exec", {31'd0, rd_ram}, 32'd0);
    check("add_daddr", {21'd0, data_addr}, 32'h010);
    check("add_sela", {30'd0, sel_a}, 32'd2);
    check("add_selb", {31'd0, sel_b}, 32'd0);
    check("add_op", {31'd0, op}, 32'd0);
    check("add_wracc", {31'd0, wr_acc}, 32'd1);
    step();
    step();
    check("sto_dec_rdram", {31'd0, rd_ram}, 32'd0);
    step();
    check("sto_wrram", {31'd0, wr_ram}, 32'd1);
    check("sto_wracc", {31'd0, wr_acc}, 32'd0);
    check("sto_daddr", {21'd0, data_addr}, 32'd3);
    step();
    check("sto_after_wrram", {31'd0, wr_ram}, 32'd0);
    step();
    step();
    check("hlt_exec_state", {29'd0, state}, {29'd0, S_EXEC});
    check_quiet("hlt_exec");
    step();
    check("p1_halted", {31'd0, halted}, 32'd1);
    check("p1_halt_state", {29'd0, state}, {29'd0, S_HALT});
    check("p1_halt_pc", {21'd0, pm_addr}, 32'd4);
    check("p1_halt_cnt", cycle_count, 32'd15);
    pulse_start();
    step();
    step();
    check("p1_sticky_state", {29'd0, state}, {29'd0, S_HALT});
    check("p1_sticky_cnt", cycle_count, 32'd15);
    check("p1_sticky_pc", {21'd0, pm_addr}, 32'd4);

    // Program 2: STO 3, HLT
    load_nops();
    rom[0] = 16'h0803;
    rom[1] = 16'h0000;
    do_reset();
    check("p2_rst_state", {29'd0, state}, {29'd0, S_IDLE});
    check("p2_rst_cnt", cycle_count, 32'd0);
    check("p2_rst_halted", {31'd0, halted}, 32'd0);
    pulse_start();
    step();
    step();
    check("p2_sto_wrram", {31'd0, wr_ram}, 32'd1);
    check("p2_sto_daddr", {21'd0, data_addr}, 32'd3);
    step();
    check("p2_sto_pulse_end", {31'd0, wr_ram}, 32'd0);
    step();
    step();
    step();
    check("p2_halted", {31'd0, halted}, 32'd1);
    check("p2_halt_cnt", cycle_count, 32'd6);
    check("p2_halt_pc", {21'd0, pm_addr}, 32'd1);
    pulse_start();
    step();
    check("p2_sticky_state", {29'd0, state}, {29'd0, S_HALT});
    check("p2_sticky_cnt", cycle_count, 32'd6);

    // Program 3: all NOP (opcode 11111), run until PC wraps
    load_nops();
    do_reset();
    pulse_start();
    for (int k = 0; k < 2047; k++) begin
      step();
      step();
      step();
    end
    check("wrap_fetch_state", {29'd0, state}, {29'd0, S_FETCH});
    check("wrap_pc_top", {21'd0, pm_addr}, 32'h7FF);
    step();
    check("nop_dec_rdram", {31'd0, rd_ram}, 32'd0);
    step();
    check("nop_exec_state", {29'd0, state}, {29'd0, S_EXEC});
    check_quiet("nop_exec");
    step();
    check("wrap_pc_zero", {21'd0, pm_addr}, 32'd0);
    check("wrap_state", {29'd0, state}, {29'd0, S_FETCH});
    check("wrap_cnt", cycle_count, 32'd6144);
    check("wrap_halted", {31'd0, halted}, 32'd0);

    // Program 4: reset lands during EXEC of STO
    load_nops();
    rom[0] = 16'h0803;
    do_reset();
    pulse_start();
    step();
    step();
    check("p4_sto_wrram", {31'd0, wr_ram}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("p4_rst_wrram", {31'd0, wr_ram}, 32'd0);
    check("p4_rst_state", {29'd0, state}, {29'd0, S_IDLE});
    check("p4_rst_pc", {21'd0, pm_addr}, 32'd0);
    check("p4_rst_cnt", cycle_count, 32'd0);
    check("p4_rst_operand", {16'd0, operand}, 32'd0);
    step();
    check("p4_idle_hold", {29'd0, state}, {29'd0, S_IDLE});
    check("p4_idle_cnt", cycle_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
